// File: rtl/falign_pkg.sv
// falign_pkg: shared FALU opcode macros and default alignment-pipe sizes.
//   No ports. Provides `FADDOP/`FSUBOP/`FMULOP and EXP_W_DEF/MAN_W_DEF/OP_W_DEF.
`ifndef FALIGN_OPCODES
`define FALIGN_OPCODES
`define FADDOP 5'h00
`define FSUBOP 5'h01
`define FMULOP 5'h02
`endif

package falign_pkg;
    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int OP_W_DEF  = 5;
endpackage

// File: rtl/falign_sticky_shr.sv
// falign_sticky_shr: combinational right shifter that folds every shifted-out bit into bit 0.
//   din  in  W     value to shift
//   sh   in  SH_W  shift amount (any value; amounts >= W leave only the sticky bit)
//   dout out W     (din >> sh) with OR of discarded bits in bit 0
module falign_sticky_shr #(
    parameter int W    = 27,
    parameter int SH_W = 8
) (
    input  logic [W-1:0]    din,
    input  logic [SH_W-1:0] sh,
    output logic [W-1:0]    dout
);
    logic sticky;
    // SV shifts by >= W yield zero, so the mask becomes all ones and the clamp falls out naturally.
    always_comb begin
        sticky = |(din & ~({W{1'b1}} << sh));
        dout   = (din >> sh) | {{(W-1){1'b0}}, sticky};
    end
endmodule

// File: rtl/falign_pipe.sv
// falign_pipe: two-stage operand alignment pipe; orders by magnitude, restores hidden bits,
//   and right-shifts the smaller significand by the exponent difference with guard/round/sticky.
//   clk, rstn                 clock, asynchronous active-low reset
//   in_valid/in_ready         input handshake; in_a/in_b {sign,exp,man}, in_op opcode
//   out_valid/out_ready       output handshake; out_op opcode of the result
//   sign_max/sign_min         signs of larger/smaller operand
//   exp_max                   effective exponent of larger operand (denormal -> 1)
//   frac_max/frac_min         {hidden,man,3'b000}; frac_min shifted with sticky in bit 0
//   swapped                   1 when B was selected as max
module falign_pipe
    import falign_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int OP_W  = OP_W_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [OP_W-1:0]        in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OP_W-1:0]        out_op,
    output logic                   sign_max,
    output logic                   sign_min,
    output logic [EXP_W-1:0]       exp_max,
    output logic [MAN_W+3:0]       frac_max,
    output logic [MAN_W+3:0]       frac_min,
    output logic                   swapped
);
    localparam int FRAC_W = MAN_W + 1;
    localparam int GRS_W  = FRAC_W + 3;

    logic              s2_ready, s1_load, s2_load;
    logic              a_sgn, b_sgn, a_hid, b_hid, b_wins;
    logic [EXP_W-1:0]  a_exp, b_exp, a_eff, b_eff, sh_amt;
    logic [MAN_W-1:0]  a_man, b_man;
    logic [GRS_W-1:0]  shr_out;

    logic              s1_v_d, s1_v_q, s1_smax_d, s1_smax_q, s1_smin_d, s1_smin_q, s1_swap_d, s1_swap_q;
    logic [OP_W-1:0]   s1_op_d, s1_op_q;
    logic [EXP_W-1:0]  s1_emax_d, s1_emax_q, s1_diff_d, s1_diff_q;
    logic [FRAC_W-1:0] s1_sigmax_d, s1_sigmax_q, s1_sigmin_d, s1_sigmin_q;

    logic              s2_v_d, s2_v_q, s2_smax_d, s2_smax_q, s2_smin_d, s2_smin_q, s2_swap_d, s2_swap_q;
    logic [OP_W-1:0]   s2_op_d, s2_op_q;
    logic [EXP_W-1:0]  s2_emax_d, s2_emax_q;
    logic [GRS_W-1:0]  s2_fmax_d, s2_fmax_q, s2_fmin_d, s2_fmin_q;

    // Handshake and S1: compare/swap. The hidden bit joins the key so a denormal
    // (eff exp 1, hidden 0) orders below a normal with exponent 1.
    always_comb begin
        s2_ready    = !s2_v_q || out_ready;
        in_ready    = !s1_v_q || s2_ready;
        s1_load     = in_valid && in_ready;
        a_sgn       = in_a[EXP_W+MAN_W];
        b_sgn       = in_b[EXP_W+MAN_W];
        a_exp       = in_a[MAN_W +: EXP_W];
        b_exp       = in_b[MAN_W +: EXP_W];
        a_man       = in_a[MAN_W-1:0];
        b_man       = in_b[MAN_W-1:0];
        a_hid       = |a_exp;
        b_hid       = |b_exp;
        a_eff       = a_hid ? a_exp : EXP_W'(1);
        b_eff       = b_hid ? b_exp : EXP_W'(1);
        b_wins      = {b_eff, b_hid, b_man} > {a_eff, a_hid, a_man};
        s1_v_d      = in_ready ? in_valid : s1_v_q;
        s1_op_d     = s1_load ? in_op : s1_op_q;
        s1_smax_d   = s1_load ? (b_wins ? b_sgn : a_sgn) : s1_smax_q;
        s1_smin_d   = s1_load ? (b_wins ? a_sgn : b_sgn) : s1_smin_q;
        s1_emax_d   = s1_load ? (b_wins ? b_eff : a_eff) : s1_emax_q;
        s1_diff_d   = s1_load ? (b_wins ? b_eff - a_eff : a_eff - b_eff) : s1_diff_q;
        s1_sigmax_d = s1_load ? (b_wins ? {b_hid, b_man} : {a_hid, a_man}) : s1_sigmax_q;
        s1_sigmin_d = s1_load ? (b_wins ? {a_hid, a_man} : {b_hid, b_man}) : s1_sigmin_q;
        s1_swap_d   = s1_load ? b_wins : s1_swap_q;
    end

    // Multiply needs both significands unshifted; only the ordering is kept.
    assign sh_amt = (s1_op_q == OP_W'(`FMULOP)) ? '0 : s1_diff_q;

    falign_sticky_shr #(.W(GRS_W), .SH_W(EXP_W)) u_shr (
        .din  ({s1_sigmin_q, 3'b000}),
        .sh   (sh_amt),
        .dout (shr_out)
    );

    always_comb begin
        s2_load   = s1_v_q && s2_ready;
        s2_v_d    = s2_ready ? s1_v_q : s2_v_q;
        s2_op_d   = s2_load ? s1_op_q : s2_op_q;
        s2_smax_d = s2_load ? s1_smax_q : s2_smax_q;
        s2_smin_d = s2_load ? s1_smin_q : s2_smin_q;
        s2_emax_d = s2_load ? s1_emax_q : s2_emax_q;
        s2_fmax_d = s2_load ? {s1_sigmax_q, 3'b000} : s2_fmax_q;
        s2_fmin_d = s2_load ? shr_out : s2_fmin_q;
        s2_swap_d = s2_load ? s1_swap_q : s2_swap_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v_q      <= 1'b0;
            s1_op_q     <= '0;
            s1_smax_q   <= 1'b0;
            s1_smin_q   <= 1'b0;
            s1_emax_q   <= '0;
            s1_diff_q   <= '0;
            s1_sigmax_q <= '0;
            s1_sigmin_q <= '0;
            s1_swap_q   <= 1'b0;
            s2_v_q      <= 1'b0;
            s2_op_q     <= '0;
            s2_smax_q   <= 1'b0;
            s2_smin_q   <= 1'b0;
            s2_emax_q   <= '0;
            s2_fmax_q   <= '0;
            s2_fmin_q   <= '0;
            s2_swap_q   <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_op_q     <= s1_op_d;
            s1_smax_q   <= s1_smax_d;
            s1_smin_q   <= s1_smin_d;
            s1_emax_q   <= s1_emax_d;
            s1_diff_q   <= s1_diff_d;
            s1_sigmax_q <= s1_sigmax_d;
            s1_sigmin_q <= s1_sigmin_d;
            s1_swap_q   <= s1_swap_d;
            s2_v_q      <= s2_v_d;
            s2_op_q     <= s2_op_d;
            s2_smax_q   <= s2_smax_d;
            s2_smin_q   <= s2_smin_d;
            s2_emax_q   <= s2_emax_d;
            s2_fmax_q   <= s2_fmax_d;
            s2_fmin_q   <= s2_fmin_d;
            s2_swap_q   <= s2_swap_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_op    = s2_op_q;
    assign sign_max  = s2_smax_q;
    assign sign_min  = s2_smin_q;
    assign exp_max   = s2_emax_q;
    assign frac_max  = s2_fmax_q;
    assign frac_min  = s2_fmin_q;
    assign swapped   = s2_swap_q;
endmodule

// File: tb/tb_falign_pipe.sv
// tb_falign_pipe: randomized and directed bench for falign_pipe against a magnitude-based reference model.
`ifndef FALIGN_OPCODES
`define FALIGN_OPCODES
`define FADDOP 5'h00
`define FSUBOP 5'h01
`define FMULOP 5'h02
`endif

module tb_falign_pipe;
    logic        clk = 1'b0, rstn = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [4:0]  in_op = '0;
    logic        in_ready, out_valid, sign_max, sign_min, swapped;
    logic [4:0]  out_op;
    logic [7:0]  exp_max;
    logic [26:0] frac_max, frac_min;

    falign_pipe dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_op(out_op), .sign_max(sign_max),
        .sign_min(sign_min), .exp_max(exp_max), .frac_max(frac_max),
        .frac_min(frac_min), .swapped(swapped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  op;
        logic        smax;
        logic        smin;
        logic [7:0]  emax;
        logic [26:0] fmax;
        logic [26:0] fmin;
        logic        sw;
    } res_t;

    res_t dut_res, prev;
    res_t q[$];
    bit   prev_stall = 0;
    int   checks = 0, errors = 0;

    assign dut_res = {out_op, sign_max, sign_min, exp_max, frac_max, frac_min, swapped};

    // IEEE magnitude order is the unsigned order of the {exp,man} bits; the shift is plain arithmetic.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        res_t r;
        logic [31:0] mx, mn;
        logic [63:0] emx, emn, d, smx, smn, f;
        r.sw = b[30:0] > a[30:0];
        mx   = r.sw ? b : a;
        mn   = r.sw ? a : b;
        emx  = (mx[30:23] == 0) ? 64'd1 : 64'(mx[30:23]);
        emn  = (mn[30:23] == 0) ? 64'd1 : 64'(mn[30:23]);
        d    = emx - emn;
        smx  = ((mx[30:23] != 0) ? 64'h800000 : 64'd0) + 64'(mn[22:0] & 23'd0) + 64'(mx[22:0]);
        smn  = ((mn[30:23] != 0) ? 64'h800000 : 64'd0) + 64'(mn[22:0]);
        f    = smn * 8;
        if (op != `FMULOP) begin
            if (d >= 27) f = (f != 0) ? 64'd1 : 64'd0;
            else f = (f >> d) | (((f % (64'd1 << d)) != 0) ? 64'd1 : 64'd0);
        end
        r.op   = op;
        r.smax = mx[31];
        r.smin = mn[31];
        r.emax = 8'(emx);
        r.fmax = 27'(smx * 8);
        r.fmin = 27'(f);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] m;
        int k = int'($urandom % 8);
        e = (k == 0) ? 8'h00 : (k == 1) ? 8'h01 : (k == 2) ? 8'hFF :
            (k < 6) ? 8'(120 + $urandom % 16) : 8'($urandom);
        m = ($urandom % 6 == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // Outputs and handshakes are sampled mid-cycle; a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            prev_stall = 0;
            chk("reset_outs", {out_valid, dut_res}, '0);
        end else begin
            if (prev_stall) chk("stall_hold", dut_res, prev);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", out_valid, 0);
                else chk("out", dut_res, q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_op));
            prev_stall = out_valid && !out_ready;
            prev = dut_res;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        int n = 0;
        in_valid = 1; in_a = a; in_b = b; in_op = op;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("send_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        in_valid = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        #1 rstn = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        chk("in_ready_after_reset", in_ready, 1);

        chk("pin_basic", model(32'h3F800000, 32'h3F000000, `FADDOP),
            {5'h00, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h2000000, 1'b0});
        chk("pin_grs", model(32'h33800001, 32'h3F800000, `FADDOP),
            {5'h00, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h0000005, 1'b1});
        chk("pin_far", model(32'h7F000000, 32'h00800000, `FADDOP),
            {5'h00, 1'b0, 1'b0, 8'hFE, 27'h4000000, 27'h0000001, 1'b0});
        chk("pin_denorm", model(32'h00800000, 32'h00000001, `FADDOP),
            {5'h00, 1'b0, 1'b0, 8'h01, 27'h4000000, 27'h0000008, 1'b0});
        chk("pin_mul", model(32'h40000000, 32'h3F800000, `FMULOP),
            {`FMULOP, 1'b0, 1'b0, 8'h80, 27'h4000000, 27'h4000000, 1'b0});

        out_ready = 1;
        send(32'h3F800000, 32'h3F000000, `FADDOP);
        send(32'h33800001, 32'h3F800000, `FADDOP);
        send(32'h7F000000, 32'h00800000, `FSUBOP);
        send(32'h00800000, 32'h00000001, `FADDOP);
        send(32'h40000000, 32'h3F800000, `FMULOP);
        send(32'hC0400000, 32'hC0400000, `FADDOP);
        drain();

        out_ready = 0;
        send(rnd_op(), rnd_op(), `FADDOP);
        send(rnd_op(), rnd_op(), `FMULOP);
        in_valid = 1; in_a = rnd_op(); in_b = rnd_op(); in_op = `FSUBOP;
        chk("in_ready_drop", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_stalled", in_ready, 0);
        chk("out_valid_stalled", out_valid, 1);
        out_ready = 1;
        send(in_a, in_b, in_op);
        send(rnd_op(), rnd_op(), `FADDOP);
        drain();

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            in_a      = rnd_op();
            in_b      = ($urandom % 16 == 0) ? in_a : rnd_op();
            in_op     = ($urandom % 4 == 0) ? `FMULOP : 5'($urandom);
            out_ready = ($urandom % 3) != 0;
        end

        out_ready = 0;
        in_valid = 1; in_a = rnd_op(); in_b = rnd_op(); in_op = `FADDOP;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_valid", out_valid, 1);
        rstn = 0;
        in_valid = 0;
        #1;
        chk("mid_reset_valid", out_valid, 0);
        chk("mid_reset_data", dut_res, 0);
        @(posedge clk); #1;
        rstn = 1;
        chk("post_reset_ready", in_ready, 1);
        chk("post_reset_valid", out_valid, 0);
        out_ready = 1;
        send(32'h3F800000, 32'h3F000000, `FADDOP);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
